// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-8 helpers for the ccff chain loader.
// The CRC items are only used when CCFF_READBACK_VERIFY_EN is defined.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    VERIFY,
    FIN
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One step of a serial CRC-8: MSB-first feedback XORed with the new bit.
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
    logic [7:0] nxt;
    nxt = {crc[6:0], 1'b0};
    if (crc[7] ^ din) nxt = nxt ^ CRC8_POLY;
    return nxt;
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Serial CRC-8 accumulator with synchronous clear and bit enable.
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge prog_clk) begin
    if (prog_reset || clear) crc <= CRC8_INIT;
    else if (en)             crc <= crc8_bit(crc, din);
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Writer-side ccff loader: streams host words LSB-first into the chain head.
// Define CCFF_READBACK_VERIFY_EN to add the CRC-checked recirculating readback.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [BIT_W-1:0]  bit_idx;
  logic [WORD_W-1:0] word_reg;
  logic              chain_full;
  logic              last_word_bit;

  assign cnt_inc       = cnt + 1'b1;
  assign chain_full    = (cnt_inc == CNT_W'(CHAIN_LEN));
  assign last_word_bit = (bit_idx == BIT_W'(WORD_W - 1));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nx      = state;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        ccff_shift_en = 1'b1;
        ccff_head     = word_reg[0];
`ifdef CCFF_READBACK_VERIFY_EN
        if (chain_full)         state_nx = VERIFY;
`else
        if (chain_full)         state_nx = FIN;
`endif
        else if (last_word_bit) state_nx = FETCH;
      end
`ifdef CCFF_READBACK_VERIFY_EN
      VERIFY: begin
        // Feeding the tail back to the head rotates the chain a full lap.
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        if (chain_full) state_nx = FIN;
      end
`endif
      FIN: begin
        done     = 1'b1;
        busy     = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      word_reg <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) cnt <= '0;
        FETCH: begin
          if (cfg_valid) begin
            word_reg <= cfg_data;
            bit_idx  <= '0;
          end
        end
        SHIFT: begin
          word_reg <= word_reg >> 1;
          bit_idx  <= bit_idx + 1'b1;
          // Counter restarts so the readback pass can reuse it.
          cnt      <= chain_full ? '0 : cnt_inc;
        end
`ifdef CCFF_READBACK_VERIFY_EN
        VERIFY: cnt <= cnt_inc;
`endif
        default: ;
      endcase
    end
  end

`ifdef CCFF_READBACK_VERIFY_EN
  logic [7:0] crc_tx, crc_rx;
  logic       crc_clear;
  logic       error_q;

  assign crc_clear = (state == IDLE) && start;

  ccff_crc8_serial u_crc_tx (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (crc_clear),
    .en         (state == SHIFT),
    .din        (ccff_head),
    .crc        (crc_tx)
  );

  ccff_crc8_serial u_crc_rx (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (crc_clear),
    .en         (state == VERIFY),
    .din        (ccff_tail),
    .crc        (crc_rx)
  );

  // The readback CRC still lacks the final tail bit at the exit edge.
  always_ff @(posedge prog_clk) begin
    if (prog_reset || crc_clear)           error_q <= 1'b0;
    else if (state == VERIFY && chain_full) error_q <= (crc_tx != crc8_bit(crc_rx, ccff_tail));
  end

  assign error = error_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: a shift-register chain model fed by the DUT, expected
// head bits queued by stimulus and checked by an independent monitor.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 10;
  localparam int WORD_W    = 8;
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int STUCK_IDX = 4;
  localparam logic [CHAIN_LEN-1:0] STUCK_MASK = CHAIN_LEN'(1) << STUCK_IDX;

  logic              prog_clk   = 1'b0;
  logic              prog_reset = 1'b1;
  logic              start      = 1'b0;
  logic [WORD_W-1:0] cfg_data   = '0;
  logic              cfg_valid  = 1'b0;
  logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic              busy, done, error;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: bits enter at the top, the tail is index 0, so after a
  // full load chain[i] holds stream bit i.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] chain_shifted;
  bit                   stuck_en = 1'b0;
  assign chain_shifted = {ccff_head, chain[CHAIN_LEN-1:1]};
  assign ccff_tail     = chain[0];

  always @(posedge prog_clk)
    if (ccff_shift_en) chain <= stuck_en ? (chain_shifted & ~STUCK_MASK) : chain_shifted;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  logic     done_q[$];
  int       verify_left = 0;
  int       bits_seen   = 0;
  int       ready_rises = 0;
  logic     ready_d     = 1'b0;
  int       tests       = 0;
  int       failures    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge prog_clk) begin
    exp_bit_t e;
    if (ccff_shift_en) begin
      if (verify_left > 0) begin
        check("verify_recirculate", ccff_head, ccff_tail);
        verify_left--;
      end else if (exp_q.size() == 0) begin
        check("unexpected_shift", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("head_bit", ccff_head, e.b);
        bits_seen++;
`ifdef CCFF_READBACK_VERIFY_EN
        if (e.last) verify_left = CHAIN_LEN;
`endif
      end
    end
    if (cfg_ready && !ready_d) ready_rises++;
    ready_d = cfg_ready;
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        check("error_at_done", error, done_q.pop_front());
        check("busy_low_with_done", busy, 1'b0);
        check("bits_left_at_done", exp_q.size(), 0);
        check("verify_left_at_done", verify_left, 0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int stall);
    int n = 0;
    while (n < 200) begin
      @(negedge prog_clk);
      if (cfg_ready) break;
      n++;
    end
    check("cfg_ready_seen", cfg_ready, 1'b1);
    repeat (stall) @(negedge prog_clk);
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(posedge prog_clk); #1;
    cfg_valid = 1'b0;
    cfg_data  = WORD_W'($urandom);
  endtask

  task automatic queue_load(input logic [NW*WORD_W-1:0] words, input logic exp_err);
    for (int i = 0; i < CHAIN_LEN; i++)
      exp_q.push_back('{b: words[i], last: (i == CHAIN_LEN - 1)});
    done_q.push_back(exp_err);
    ready_rises = 0;
    bits_seen   = 0;
  endtask

  task automatic run_load(input logic [NW*WORD_W-1:0] words, input int stall,
                          input bit busy_start, input logic exp_err, input bit chk_chain);
    int n = 0;
    queue_load(words, exp_err);
    @(posedge prog_clk); #1;
    pulse_start();
    check("error_cleared_by_start", error, 1'b0);
    for (int w = 0; w < NW; w++) begin
      send_word(words[w*WORD_W +: WORD_W], (w > 0) ? stall : 0);
      if (w == 0 && busy_start) pulse_start();
    end
    while (n < 300 && done_q.size() != 0) begin
      @(posedge prog_clk);
      n++;
    end
    check("done_seen", done_q.size(), 0);
    repeat (3) @(posedge prog_clk);
    #1;
    if (chk_chain) check("chain_contents", chain, words[CHAIN_LEN-1:0]);
    check("ready_windows", ready_rises, NW);
    check("idle_after_load", {busy, cfg_ready, ccff_shift_en, done, ccff_head}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW*WORD_W-1:0] rw;
    int n;

    repeat (3) @(posedge prog_clk);
    #1;
    check("reset_outputs", {busy, cfg_ready, ccff_shift_en, done, error, ccff_head}, 0);
    prog_reset = 1'b0;

    run_load(16'h02A5, 0, 1'b0, 1'b0, 1'b1);
    run_load(16'h01FF, 0, 1'b0, 1'b0, 1'b1);
    run_load(16'h035A, 5, 1'b0, 1'b0, 1'b1);
    run_load(16'h035A, 0, 1'b0, 1'b0, 1'b1);
    run_load(16'h00C3, 0, 1'b1, 1'b0, 1'b1);

    // Reset after the third bit reaches the chain.
    queue_load(16'h03F0, 1'b0);
    @(posedge prog_clk); #1;
    pulse_start();
    send_word(8'hF0, 0);
    n = 0;
    while (n < 100 && bits_seen < 3) begin
      @(posedge prog_clk);
      n++;
    end
    check("bits_before_reset", bits_seen, 3);
    #1;
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;
    prog_reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    verify_left = 0;
    check("reset_midload_outputs", {busy, cfg_ready, ccff_shift_en, done}, 0);
    run_load(16'h2B6D, 0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      rw = (NW*WORD_W)'($urandom);
      run_load(rw, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

`ifdef CCFF_READBACK_VERIFY_EN
    stuck_en = 1'b1;
    run_load(16'hFFFF, 0, 1'b0, 1'b1, 1'b0);
    stuck_en = 1'b0;
    repeat (5) @(posedge prog_clk);
    #1;
    check("error_sticky", error, 1'b1);
    run_load(16'h1234, 0, 1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
